rx_frame_filter: RTL and testbench

//   Store-and-forward frame buffer directly downstream of the MAC RX pipe adapter. It pulls 73-bit
//   {tlast,tdata,tkeep} words from the RX pipe and buffers each frame until its last word arrives.

---
 rtl/nic_pkg.sv | 27 ++
 rtl/rx_frame_ram.sv | 44 ++++
 rtl/rx_frame_filter.sv | 169 ++++++++++++++++
 tb/tb_rx_frame_filter.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/nic_pkg.sv
// rtl/nic_pkg.sv - shared constants, field indices and FSM encoding for the RX frame filter
package nic_pkg;

  localparam int DATA_W     = 64;
  localparam int KEEP_W     = 8;
  localparam int WORD_W     = DATA_W + KEEP_W + 1;
  localparam int DEF_ADDR_W = 9;

  localparam int LAST_BIT = 72;
  localparam int DATA_MSB = 71;
  localparam int DATA_LSB = 8;
  localparam int KEEP_MSB = 7;

  // An all-zero keep on the last word is how the MAC flags an FCS failure
  localparam logic [KEEP_W-1:0] BAD_KEEP = 8'h00;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_STORE = 2'd1,
    ST_DROP  = 2'd2
  } state_e;

  function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic en);
    return (en && (val != 32'hFFFF_FFFF)) ? val + 32'd1 : val;
  endfunction

endpackage

// File: rtl/rx_frame_ram.sv
// rtl/rx_frame_ram.sv - simple dual-port frame RAM, one write port, one registered read port
module rx_frame_ram #(
  parameter int ADDR_W = 9,
  parameter int WORD_W = 73
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WORD_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WORD_W-1:0] rd_data
);

  logic [WORD_W-1:0] mem_q [2**ADDR_W];
  logic [WORD_W-1:0] rd_data_q;
  logic [WORD_W-1:0] rd_data_d;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  // The read register holds its word until the next read so it can act as the output stage
  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) begin
      rd_data_d = mem_q[rd_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/rx_frame_filter.sv
// rtl/rx_frame_filter.sv - store-and-forward RX frame buffer dropping FCS-failed and overflowed frames
// Optional RX_FRAME_FILTER_STATS_EN adds saturating good/FCS-drop/overflow-drop frame counters.
module rx_frame_filter
  import nic_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  output logic              in_req,
  input  logic              in_ack,
  input  logic [WORD_W-1:0] in_data,
  input  logic              out_req,
  output logic              out_ack,
  output logic [WORD_W-1:0] out_data,
  output logic              frame_drop
`ifdef RX_FRAME_FILTER_STATS_EN
  ,
  output logic [31:0]       good_frames,
  output logic [31:0]       bad_fcs_frames,
  output logic [31:0]       ovf_frames
`endif
);

  localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

  state_e            state_q, state_d;
  logic              in_req_q, in_req_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] commit_ptr_q, commit_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic              out_ack_q, out_ack_d;
  logic              frame_drop_q, frame_drop_d;

  logic              accept;
  logic              in_last;
  logic [KEEP_W-1:0] in_keep;
  logic [ADDR_W-1:0] wr_ptr_inc;
  logic              full;
  logic              ram_wr_en;
  logic              ram_rd_en;
  logic              ev_commit;
  logic              ev_drop_fcs;
  logic              ev_drop_ovf;

  assign accept     = in_req_q && in_ack;
  assign in_last    = in_data[LAST_BIT];
  assign in_keep    = in_data[KEEP_MSB:0];
  assign wr_ptr_inc = wr_ptr_q + PTR_ONE;
  assign full       = (wr_ptr_inc == rd_ptr_q);

  // Write side: speculative wr_ptr, published to the reader only through commit_ptr
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    commit_ptr_d = commit_ptr_q;
    ram_wr_en    = 1'b0;
    ev_commit    = 1'b0;
    ev_drop_fcs  = 1'b0;
    ev_drop_ovf  = 1'b0;
    case (state_q)
      ST_IDLE, ST_STORE: begin
        if (accept) begin
          if (in_last && (in_keep == BAD_KEEP)) begin
            wr_ptr_d    = commit_ptr_q;
            ev_drop_fcs = 1'b1;
            state_d     = ST_IDLE;
          end else if (full) begin
            wr_ptr_d    = commit_ptr_q;
            ev_drop_ovf = 1'b1;
            state_d     = in_last ? ST_IDLE : ST_DROP;
          end else begin
            ram_wr_en = 1'b1;
            wr_ptr_d  = wr_ptr_inc;
            if (in_last) begin
              commit_ptr_d = wr_ptr_inc;
              ev_commit    = 1'b1;
              state_d      = ST_IDLE;
            end else begin
              state_d = ST_STORE;
            end
          end
        end
      end
      ST_DROP: begin
        if (accept && in_last) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Read side: refill the output register whenever it is empty or being drained this cycle
  always_comb begin
    in_req_d     = 1'b1;
    frame_drop_d = ev_drop_fcs || ev_drop_ovf;
    ram_rd_en    = (rd_ptr_q != commit_ptr_q) && (!out_ack_q || out_req);
    rd_ptr_d     = ram_rd_en ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    out_ack_d    = ram_rd_en ? 1'b1 : (out_ack_q && !out_req);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      in_req_q     <= 1'b0;
      wr_ptr_q     <= '0;
      commit_ptr_q <= '0;
      rd_ptr_q     <= '0;
      out_ack_q    <= 1'b0;
      frame_drop_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      in_req_q     <= in_req_d;
      wr_ptr_q     <= wr_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      out_ack_q    <= out_ack_d;
      frame_drop_q <= frame_drop_d;
    end
  end

  rx_frame_ram #(
    .ADDR_W (ADDR_W),
    .WORD_W (WORD_W)
  ) u_ram (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (ram_wr_en),
    .wr_addr (wr_ptr_q),
    .wr_data (in_data),
    .rd_en   (ram_rd_en),
    .rd_addr (rd_ptr_q),
    .rd_data (out_data)
  );

  assign in_req     = in_req_q;
  assign out_ack    = out_ack_q;
  assign frame_drop = frame_drop_q;

`ifdef RX_FRAME_FILTER_STATS_EN
  logic [31:0] good_frames_q, good_frames_d;
  logic [31:0] bad_fcs_frames_q, bad_fcs_frames_d;
  logic [31:0] ovf_frames_q, ovf_frames_d;

  always_comb begin
    good_frames_d    = sat_inc(good_frames_q, ev_commit);
    bad_fcs_frames_d = sat_inc(bad_fcs_frames_q, ev_drop_fcs);
    ovf_frames_d     = sat_inc(ovf_frames_q, ev_drop_ovf);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      good_frames_q    <= '0;
      bad_fcs_frames_q <= '0;
      ovf_frames_q     <= '0;
    end else begin
      good_frames_q    <= good_frames_d;
      bad_fcs_frames_q <= bad_fcs_frames_d;
      ovf_frames_q     <= ovf_frames_d;
    end
  end

  assign good_frames    = good_frames_q;
  assign bad_fcs_frames = bad_fcs_frames_q;
  assign ovf_frames     = ovf_frames_q;
`endif

endmodule

// File: tb/tb_rx_frame_filter.sv
// tb/tb_rx_frame_filter.sv - directed self-checking bench for rx_frame_filter (ADDR_W=4 instance)
// Define RX_FRAME_FILTER_STATS_EN to also exercise the statistics counters.
module tb_rx_frame_filter;

  localparam int WW = 73;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_req;
  logic          in_ack = 1'b0;
  logic [WW-1:0] in_data = '0;
  logic          out_req = 1'b0;
  logic          out_ack;
  logic [WW-1:0] out_data;
  logic          frame_drop;
`ifdef RX_FRAME_FILTER_STATS_EN
  logic [31:0]   good_frames;
  logic [31:0]   bad_fcs_frames;
  logic [31:0]   ovf_frames;
`endif

  int errors = 0;
  int checks = 0;
  int drop_cnt = 0;
  logic [WW-1:0] got_q[$];
  logic [WW-1:0] exp_q[$];

  always #5 clk = ~clk;

  rx_frame_filter #(.ADDR_W(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_req     (in_req),
    .in_ack     (in_ack),
    .in_data    (in_data),
    .out_req    (out_req),
    .out_ack    (out_ack),
    .out_data   (out_data),
    .frame_drop (frame_drop)
`ifdef RX_FRAME_FILTER_STATS_EN
    ,
    .good_frames    (good_frames),
    .bad_fcs_frames (bad_fcs_frames),
    .ovf_frames     (ovf_frames)
`endif
  );

  // Inputs change just after posedge, so the negedge sees exactly what the next edge will act on
  always @(negedge clk) begin
    if (!reset) begin
      if (out_req && out_ack) got_q.push_back(out_data);
      if (frame_drop) drop_cnt++;
    end
  end

  function automatic logic [WW-1:0] mk(input logic last, input int idx, input logic [7:0] keep);
    logic [63:0] d;
    d = 64'hA5C3_0000_0000_0000 | 64'(idx);
    return {last, d, keep};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic last, input int idx, input logic [7:0] keep, input logic record);
    in_ack  = 1'b1;
    in_data = mk(last, idx, keep);
    if (record) exp_q.push_back(in_data);
    tick();
    in_ack = 1'b0;
  endtask

  task automatic drain(input int n);
    int budget;
    budget = 0;
    out_req = 1'b1;
    while (got_q.size() < n && budget < 60) begin
      tick();
      budget++;
    end
    out_req = 1'b0;
    checks++;
    if (got_q.size() != n) begin
      errors++;
      $display("FAIL drain_count got=%0d want=%0d", got_q.size(), n);
    end
  endtask

  task automatic compare_words(input string name);
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= got_q.size()) begin
        errors++;
        $display("FAIL %s word%0d missing want=%h", name, i, exp_q[i]);
      end else if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL %s word%0d got=%h want=%h", name, i, got_q[i], exp_q[i]);
      end
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    checks++; if (in_req !== 1'b0) begin errors++; $display("FAIL reset_in_req got=%b want=0", in_req); end
    checks++; if (out_ack !== 1'b0) begin errors++; $display("FAIL reset_out_ack got=%b want=0", out_ack); end
    checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_out_data got=%h want=0", out_data); end
    checks++; if (frame_drop !== 1'b0) begin errors++; $display("FAIL reset_frame_drop got=%b want=0", frame_drop); end
    reset = 1'b0;
    tick();
    checks++; if (in_req !== 1'b1) begin errors++; $display("FAIL post_reset_in_req got=%b want=1", in_req); end
  endtask

  task automatic test_good_frame();
    drop_cnt = 0;
    send(1'b0, 1, 8'hFF, 1'b1);
    send(1'b0, 2, 8'hFF, 1'b1);
    send(1'b1, 3, 8'h0F, 1'b1);
    checks++; if (out_ack !== 1'b0) begin errors++; $display("FAIL good_ack_early got=%b want=0", out_ack); end
    tick();
    checks++; if (out_ack !== 1'b1) begin errors++; $display("FAIL good_ack_latency got=%b want=1", out_ack); end
    drain(3);
    compare_words("good_frame");
    checks++; if (drop_cnt !== 0) begin errors++; $display("FAIL good_no_drop got=%0d want=0", drop_cnt); end
  endtask

  task automatic test_bad_fcs();
    drop_cnt = 0;
    send(1'b0, 10, 8'hFF, 1'b0);
    send(1'b0, 11, 8'hFF, 1'b0);
    send(1'b0, 12, 8'hFF, 1'b0);
    send(1'b1, 13, 8'h00, 1'b0);
    checks++; if (frame_drop !== 1'b1) begin errors++; $display("FAIL fcs_pulse got=%b want=1", frame_drop); end
    tick();
    checks++; if (frame_drop !== 1'b0) begin errors++; $display("FAIL fcs_pulse_width got=%b want=0", frame_drop); end
    checks++; if (dut.wr_ptr_q !== 4'd3) begin errors++; $display("FAIL fcs_wr_ptr got=%0d want=3", dut.wr_ptr_q); end
    repeat (3) tick();
    checks++; if (out_ack !== 1'b0) begin errors++; $display("FAIL fcs_no_output got=%b want=0", out_ack); end
    checks++; if (drop_cnt !== 1) begin errors++; $display("FAIL fcs_drop_count got=%0d want=1", drop_cnt); end
  endtask

  task automatic test_overflow();
    drop_cnt = 0;
    for (int i = 1; i <= 20; i++) send(i == 20, 100 + i, 8'hFF, 1'b0);
    send(1'b0, 200, 8'hFF, 1'b1);
    send(1'b1, 201, 8'h3F, 1'b1);
    repeat (3) tick();
    checks++; if (drop_cnt !== 1) begin errors++; $display("FAIL ovf_drop_count got=%0d want=1", drop_cnt); end
    drain(2);
    compare_words("overflow");
`ifdef RX_FRAME_FILTER_STATS_EN
    checks++; if (good_frames !== 32'd2) begin errors++; $display("FAIL stats_good got=%0d want=2", good_frames); end
    checks++; if (bad_fcs_frames !== 32'd1) begin errors++; $display("FAIL stats_fcs got=%0d want=1", bad_fcs_frames); end
    checks++; if (ovf_frames !== 32'd1) begin errors++; $display("FAIL stats_ovf got=%0d want=1", ovf_frames); end
`endif
  endtask

  task automatic test_back_to_back();
    drop_cnt = 0;
    fork
      begin
        send(1'b0, 300, 8'hFF, 1'b1);
        send(1'b0, 301, 8'hFF, 1'b1);
        send(1'b1, 302, 8'h01, 1'b1);
        send(1'b0, 310, 8'hFF, 1'b1);
        send(1'b1, 311, 8'h80, 1'b1);
      end
      begin
        for (int c = 0; c < 30; c++) begin
          out_req = ~out_req;
          tick();
        end
      end
    join
    out_req = 1'b0;
    checks++; if (got_q.size() != 5) begin errors++; $display("FAIL b2b_count got=%0d want=5", got_q.size()); end
    compare_words("back_to_back");
    checks++; if (drop_cnt !== 0) begin errors++; $display("FAIL b2b_no_drop got=%0d want=0", drop_cnt); end
  endtask

  task automatic test_reset_mid_frame();
    send(1'b0, 400, 8'hFF, 1'b0);
    send(1'b1, 401, 8'hFF, 1'b0);
    tick();
    checks++; if (out_ack !== 1'b1) begin errors++; $display("FAIL mid_pending_ack got=%b want=1", out_ack); end
    send(1'b0, 410, 8'hFF, 1'b0);
    send(1'b0, 411, 8'hFF, 1'b0);
    reset = 1'b1;
    tick();
    checks++; if (out_ack !== 1'b0) begin errors++; $display("FAIL mid_reset_ack got=%b want=0", out_ack); end
    checks++; if (in_req !== 1'b0) begin errors++; $display("FAIL mid_reset_in_req got=%b want=0", in_req); end
    reset = 1'b0;
    got_q.delete();
    drop_cnt = 0;
    tick();
    send(1'b0, 420, 8'hFF, 1'b1);
    send(1'b1, 421, 8'h07, 1'b1);
    drain(2);
    compare_words("after_reset");
    checks++; if (drop_cnt !== 0) begin errors++; $display("FAIL mid_no_drop got=%0d want=0", drop_cnt); end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_fcs();
    test_overflow();
    test_back_to_back();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "bench time limit");
  end

endmodule
